// File: rtl/ac97_pkg.sv
// Shared AC97 scheduler definitions: FSM states, codec register map and init data.
package ac97_pkg;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD
  } state_e;

  // What the current ISSUE frame is carrying, so its completion can be handled.
  typedef enum logic [1:0] {
    K_VOL,
    K_HWR,
    K_HRD
  } kind_e;

  localparam int unsigned INIT_LEN     = 10;
  localparam int unsigned INIT_VOL_IDX = 3;

  localparam logic [6:0] REG_HP_VOL   = 7'h04;
  localparam logic [6:0] REG_BEEP     = 7'h0A;
  localparam logic [6:0] REG_MIC_VOL  = 7'h0E;
  localparam logic [6:0] REG_PCM_GAIN = 7'h18;
  localparam logic [6:0] REG_REC_SEL  = 7'h1A;
  localparam logic [6:0] REG_REC_GAIN = 7'h1C;
  localparam logic [6:0] REG_GP       = 7'h20;
  localparam logic [6:0] REG_EXT_CTRL = 7'h2A;
  localparam logic [6:0] REG_DAC_RATE = 7'h2C;
  localparam logic [6:0] REG_ADC_RATE = 7'h32;

  localparam logic [15:0] DAT_EXT_CTRL = 16'h0001;
  localparam logic [15:0] DAT_RATE_8K  = 16'h1F40;
  localparam logic [15:0] DAT_PCM_GAIN = 16'h0808;
  localparam logic [15:0] DAT_REC_GAIN = 16'h0F0F;
  localparam logic [15:0] DAT_MIC_VOL  = 16'h8048;
  localparam logic [15:0] DAT_BEEP     = 16'h0000;
  localparam logic [15:0] DAT_GP       = 16'h8000;

  // Codec volume registers are attenuation, so 31 (loudest) maps to 0.
  function automatic logic [15:0] vol_word(input logic [4:0] v);
    logic [4:0] a;
    a = 5'd31 - v;
    return {3'b000, a, 3'b000, a};
  endfunction

  function automatic logic [15:0] src_word(input logic [2:0] s);
    return {5'b00000, s, 5'b00000, s};
  endfunction

endpackage

// File: rtl/ac97_init_rom.sv
// Codec init command table; entries depending on volume/source are computed live.
module ac97_init_rom
  import ac97_pkg::*;
(
  input  logic [3:0]  index,
  input  logic [4:0]  volume,
  input  logic [2:0]  source,
  output logic [23:0] cmd
);

  always_comb begin
    cmd = '0;
    case (index)
      4'd0:    cmd = {1'b0, REG_EXT_CTRL, DAT_EXT_CTRL};
      4'd1:    cmd = {1'b0, REG_DAC_RATE, DAT_RATE_8K};
      4'd2:    cmd = {1'b0, REG_ADC_RATE, DAT_RATE_8K};
      4'd3:    cmd = {1'b0, REG_HP_VOL,   vol_word(volume)};
      4'd4:    cmd = {1'b0, REG_PCM_GAIN, DAT_PCM_GAIN};
      4'd5:    cmd = {1'b0, REG_REC_SEL,  src_word(source)};
      4'd6:    cmd = {1'b0, REG_REC_GAIN, DAT_REC_GAIN};
      4'd7:    cmd = {1'b0, REG_MIC_VOL,  DAT_MIC_VOL};
      4'd8:    cmd = {1'b0, REG_BEEP,     DAT_BEEP};
      4'd9:    cmd = {1'b0, REG_GP,       DAT_GP};
      default: cmd = '0;
    endcase
  end

endmodule

// File: rtl/ac97_cmd_scheduler.sv
// AC97 command-slot scheduler: init sequence, volume tracking and host register access.
// Define AC97_READBACK_EN to build host register reads (WAIT_RD); otherwise reads ack with error.
module ac97_cmd_scheduler
  import ac97_pkg::*;
#(
  parameter int RD_TIMEOUT = 4
) (
  input  logic        clock_27mhz,
  input  logic        reset,
  input  logic        frame_ready,
  input  logic [4:0]  volume,
  input  logic [2:0]  source,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic        host_err,
  output logic [15:0] host_rdata,
  input  logic        status_valid,
  input  logic [6:0]  status_addr,
  input  logic [15:0] status_data,
  output logic [7:0]  command_address,
  output logic [15:0] command_data,
  output logic        command_valid,
  output logic        init_done
);

  state_e      state_q;
  kind_e       kind_q;
  logic [3:0]  idx_q;
  logic        cmd_valid_q;
  logic [7:0]  cmd_addr_q;
  logic [15:0] cmd_data_q;
  logic        ack_q;
  logic        err_q;
  logic [15:0] rdata_q;
  logic        init_done_q;
  logic [4:0]  last_vol_q;

  logic [23:0] rom_cmd;
  logic        vol_pending;
  logic        grant_vol;
  logic        grant_host;

`ifdef AC97_READBACK_EN
  logic [6:0]  haddr_q;
  logic [15:0] cnt_q;
`else
  logic        unused_status;
  assign unused_status = ^{status_valid, status_addr, status_data};
`endif

  ac97_init_rom u_rom (
    .index  (idx_q),
    .volume (volume),
    .source (source),
    .cmd    (rom_cmd)
  );

  assign vol_pending = (volume != last_vol_q);

  // A finished volume write may hand straight over to the next command in the same
  // frame_ready; a finished host write may not re-grant the host it is acking.
  always_comb begin
    grant_vol  = 1'b0;
    grant_host = 1'b0;
    if (frame_ready && init_done_q &&
        (state_q == S_IDLE || (state_q == S_ISSUE && kind_q != K_HRD))) begin
      if (vol_pending) begin
        grant_vol = 1'b1;
      end else if (host_req && !ack_q && !(state_q == S_ISSUE && kind_q == K_HWR)) begin
        grant_host = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      state_q     <= S_INIT;
      kind_q      <= K_VOL;
      idx_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= 8'h80;
      cmd_data_q  <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
      last_vol_q  <= '0;
`ifdef AC97_READBACK_EN
      haddr_q     <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          if (frame_ready) begin
            if (idx_q != 4'(INIT_LEN)) begin
              cmd_valid_q              <= 1'b1;
              {cmd_addr_q, cmd_data_q} <= rom_cmd;
              if (idx_q == 4'(INIT_VOL_IDX)) last_vol_q <= volume;
              idx_q <= idx_q + 4'd1;
            end else begin
              cmd_valid_q <= 1'b0;
              cmd_addr_q  <= 8'h80;
              cmd_data_q  <= '0;
              init_done_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end
        S_IDLE: begin
          if (frame_ready) begin
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= 8'h80;
            cmd_data_q  <= '0;
          end
        end
        S_ISSUE: begin
          if (frame_ready) begin
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= 8'h80;
            cmd_data_q  <= '0;
            state_q     <= S_IDLE;
            if (kind_q == K_HWR) begin
              ack_q   <= 1'b1;
              err_q   <= 1'b0;
              rdata_q <= '0;
            end
`ifdef AC97_READBACK_EN
            if (kind_q == K_HRD) begin
              cnt_q   <= '0;
              state_q <= S_WAIT_RD;
            end
`endif
          end
        end
`ifdef AC97_READBACK_EN
        S_WAIT_RD: begin
          if (status_valid && status_addr == haddr_q) begin
            ack_q   <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= status_data;
            state_q <= S_IDLE;
          end else if (frame_ready) begin
            if (cnt_q == 16'(RD_TIMEOUT - 1)) begin
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
`endif
        default: state_q <= S_INIT;
      endcase

      if (grant_vol) begin
        cmd_valid_q <= 1'b1;
        cmd_addr_q  <= {1'b0, REG_HP_VOL};
        cmd_data_q  <= vol_word(volume);
        last_vol_q  <= volume;
        kind_q      <= K_VOL;
        state_q     <= S_ISSUE;
      end else if (grant_host) begin
        if (host_we) begin
          cmd_valid_q <= 1'b1;
          cmd_addr_q  <= {1'b0, host_addr};
          cmd_data_q  <= host_wdata;
          kind_q      <= K_HWR;
          state_q     <= S_ISSUE;
        end else begin
`ifdef AC97_READBACK_EN
          cmd_valid_q <= 1'b1;
          cmd_addr_q  <= {1'b1, host_addr};
          cmd_data_q  <= '0;
          haddr_q     <= host_addr;
          kind_q      <= K_HRD;
          state_q     <= S_ISSUE;
`else
          ack_q       <= 1'b1;
          err_q       <= 1'b1;
          rdata_q     <= '0;
`endif
        end
      end
    end
  end

  assign command_valid   = cmd_valid_q;
  assign command_address = cmd_addr_q;
  assign command_data    = cmd_data_q;
  assign host_ack        = ack_q;
  assign host_err        = err_q;
  assign host_rdata      = rdata_q;
  assign init_done       = init_done_q;

endmodule

// File: tb/tb_ac97_cmd_scheduler.sv
// Directed self-checking bench for ac97_cmd_scheduler (both AC97_READBACK_EN builds).
module tb_ac97_cmd_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_ready = 1'b0;
  logic [4:0]  volume = 5'd31;
  logic [2:0]  source = 3'd5;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [6:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ack;
  logic        host_err;
  logic [15:0] host_rdata;
  logic        status_valid = 1'b0;
  logic [6:0]  status_addr = '0;
  logic [15:0] status_data = '0;
  logic [7:0]  command_address;
  logic [15:0] command_data;
  logic        command_valid;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  ac97_cmd_scheduler #(.RD_TIMEOUT(4)) dut (
    .clock_27mhz     (clk),
    .reset           (reset),
    .frame_ready     (frame_ready),
    .volume          (volume),
    .source          (source),
    .host_req        (host_req),
    .host_we         (host_we),
    .host_addr       (host_addr),
    .host_wdata      (host_wdata),
    .host_ack        (host_ack),
    .host_err        (host_err),
    .host_rdata      (host_rdata),
    .status_valid    (status_valid),
    .status_addr     (status_addr),
    .status_data     (status_data),
    .command_address (command_address),
    .command_data    (command_data),
    .command_valid   (command_valid),
    .init_done       (init_done)
  );

  always #5 clk = ~clk;

  // Returns on the falling edge right after the edge that sampled frame_ready.
  task automatic frame();
    repeat (4) @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({command_valid, command_address, command_data, host_ack, host_err, host_rdata, init_done} !==
        {1'b0, 8'h80, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got v=%b a=%h d=%h ack=%b err=%b rd=%h done=%b", command_valid,
               command_address, command_data, host_ack, host_err, host_rdata, init_done);
    end
    reset = 1'b0;
  endtask

  task automatic test_init();
    logic [23:0] exp [10];
    exp = '{24'h2A0001, 24'h2C1F40, 24'h321F40, 24'h040000, 24'h180808,
            24'h1A0505, 24'h1C0F0F, 24'h0E8048, 24'h0A0000, 24'h208000};
    for (int i = 0; i < 10; i++) begin
      frame();
      checks++;
      if ({command_valid, command_address, command_data, init_done} !== {1'b1, exp[i], 1'b0}) begin
        errors++;
        $display("FAIL init_cmd%0d got v=%b cmd=%h%h done=%b exp %h", i, command_valid,
                 command_address, command_data, init_done, exp[i]);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({command_valid, command_address, command_data} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL init_hold%0d got v=%b cmd=%h%h exp %h", i, command_valid,
                 command_address, command_data, exp[i]);
      end
    end
    frame();
    checks++;
    if ({command_valid, command_address, command_data, init_done} !== {1'b0, 8'h80, 16'h0, 1'b1}) begin
      errors++;
      $display("FAIL init_done got v=%b cmd=%h%h done=%b exp 0 800000 1", command_valid,
               command_address, command_data, init_done);
    end
    frame();
    checks++;
    if ({command_valid, command_address} !== {1'b0, 8'h80}) begin
      errors++;
      $display("FAIL idle_quiet got v=%b a=%h exp 0 80", command_valid, command_address);
    end
  endtask

  task automatic test_host_write();
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'h18; host_wdata = 16'h0A0A;
    frame();
    checks++;
    if ({command_valid, command_address, command_data, host_ack} !== {1'b1, 24'h180A0A, 1'b0}) begin
      errors++;
      $display("FAIL wr_cmd got v=%b cmd=%h%h ack=%b exp 1 180A0A 0", command_valid,
               command_address, command_data, host_ack);
    end
    host_wdata = 16'hFFFF;
    host_addr  = 7'h11;
    repeat (2) @(negedge clk);
    checks++;
    if ({command_address, command_data} !== 24'h180A0A) begin
      errors++;
      $display("FAIL wr_sampled got %h%h exp 180A0A", command_address, command_data);
    end
    frame();
    checks++;
    if ({host_ack, host_err, command_valid} !== 3'b100) begin
      errors++;
      $display("FAIL wr_ack got ack=%b err=%b v=%b exp 1 0 0", host_ack, host_err, command_valid);
    end
    host_req = 1'b0;
    @(negedge clk);
    checks++;
    if (host_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack_pulse got %b exp 0", host_ack);
    end
  endtask

  task automatic test_host_read();
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h7C;
    frame();
`ifdef AC97_READBACK_EN
    checks++;
    if ({command_valid, command_address, command_data} !== {1'b1, 24'hFC0000}) begin
      errors++;
      $display("FAIL rd_cmd got v=%b cmd=%h%h exp 1 FC0000", command_valid, command_address, command_data);
    end
    frame();
    frame();
    status_valid = 1'b1; status_addr = 7'h7A; status_data = 16'h1234;
    @(negedge clk);
    status_addr = 7'h7C; status_data = 16'h4E53;
    checks++;
    if (host_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_nomatch got ack=%b exp 0", host_ack);
    end
    @(negedge clk);
    status_valid = 1'b0;
    checks++;
    if ({host_ack, host_err, host_rdata} !== {1'b1, 1'b0, 16'h4E53}) begin
      errors++;
      $display("FAIL rd_ack got ack=%b err=%b rd=%h exp 1 0 4E53", host_ack, host_err, host_rdata);
    end
`else
    checks++;
    if ({host_ack, host_err, host_rdata, command_valid} !== {1'b1, 1'b1, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL rd_err_ack got ack=%b err=%b rd=%h v=%b exp 1 1 0000 0", host_ack, host_err,
               host_rdata, command_valid);
    end
`endif
    host_req = 1'b0;
  endtask

  task automatic test_read_timeout();
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h26;
    frame();
`ifdef AC97_READBACK_EN
    frame();
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) begin
        status_valid = 1'b1; status_addr = 7'h27; status_data = 16'hBEEF;
        @(negedge clk);
        status_valid = 1'b0;
      end
      frame();
      checks++;
      if (host_ack !== 1'b0) begin
        errors++;
        $display("FAIL to_early%0d got ack=%b exp 0", i, host_ack);
      end
    end
    frame();
`endif
    checks++;
    if ({host_ack, host_err, host_rdata} !== {1'b1, 1'b1, 16'h0}) begin
      errors++;
      $display("FAIL to_ack got ack=%b err=%b rd=%h exp 1 1 0000", host_ack, host_err, host_rdata);
    end
    host_req = 1'b0;
  endtask

  task automatic test_vol_priority();
    volume = 5'd10;
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'h1C; host_wdata = 16'h1234;
    frame();
    checks++;
    if ({command_valid, command_address, command_data} !== {1'b1, 24'h041515}) begin
      errors++;
      $display("FAIL prio_vol got v=%b cmd=%h%h exp 1 041515", command_valid, command_address, command_data);
    end
    frame();
    checks++;
    if ({command_valid, command_address, command_data, host_ack} !== {1'b1, 24'h1C1234, 1'b0}) begin
      errors++;
      $display("FAIL prio_host got v=%b cmd=%h%h ack=%b exp 1 1C1234 0", command_valid,
               command_address, command_data, host_ack);
    end
    frame();
    checks++;
    if ({host_ack, host_err} !== 2'b10) begin
      errors++;
      $display("FAIL prio_ack got ack=%b err=%b exp 1 0", host_ack, host_err);
    end
    host_req = 1'b0;
  endtask

  task automatic test_volume_repend();
    volume = 5'd20;
    frame();
    checks++;
    if ({command_valid, command_address, command_data} !== {1'b1, 24'h040B0B}) begin
      errors++;
      $display("FAIL vol_first got v=%b cmd=%h%h exp 1 040B0B", command_valid, command_address, command_data);
    end
    volume = 5'd0;
    frame();
    checks++;
    if ({command_valid, command_address, command_data} !== {1'b1, 24'h041F1F}) begin
      errors++;
      $display("FAIL vol_repend got v=%b cmd=%h%h exp 1 041F1F", command_valid, command_address, command_data);
    end
    frame();
    checks++;
    if (command_valid !== 1'b0) begin
      errors++;
      $display("FAIL vol_settle got v=%b exp 0", command_valid);
    end
  endtask

  task automatic test_reset_mid();
    host_req = 1'b1; host_addr = 7'h30;
`ifdef AC97_READBACK_EN
    host_we = 1'b0;
    frame();
    frame();
`else
    host_we = 1'b1; host_wdata = 16'h5555;
    frame();
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    host_req = 1'b0;
    checks++;
    if ({host_ack, command_valid, command_address, init_done} !== {1'b0, 1'b0, 8'h80, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid got ack=%b v=%b a=%h done=%b exp 0 0 80 0", host_ack, command_valid,
               command_address, init_done);
    end
    frame();
    checks++;
    if ({command_valid, command_address, command_data, host_ack} !== {1'b1, 24'h2A0001, 1'b0}) begin
      errors++;
      $display("FAIL rst_restart got v=%b cmd=%h%h ack=%b exp 1 2A0001 0", command_valid,
               command_address, command_data, host_ack);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_host_write();
    test_host_read();
    test_read_timeout();
    test_vol_priority();
    test_volume_repend();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
